// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: decode-stage forwarding selects, load-use stall and WB write control; ports clk, reset (sync active-low), ins/ins_valid/interrupt in, mux_sel_A/B, imm_sel, stall, wb_we, wb_addr out
module hazard_forward_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [23:0] ins,
  input  logic       ins_valid,
  input  logic       interrupt,
  output logic [1:0] mux_sel_A,
  output logic [1:0] mux_sel_B,
  output logic       imm_sel,
  output logic       stall,
  output logic       wb_we,
  output logic [2:0] wb_addr
);
  logic [3:0] op;
  logic [2:0] rd, rs1, rs2;
  logic is_r, is_i, is_ld, is_st, rd_a, rd_b, wr, bubble, unused;
  logic ex_v_q, ex_v_d, ex_ld_q, ex_ld_d, dm_v_q, dm_v_d, wb_v_q, wb_v_d;
  logic [2:0] ex_rd_q, ex_rd_d, dm_rd_q, dm_rd_d, wb_rd_q, wb_rd_d;

  function automatic logic [1:0] fwd(input logic [2:0] s, input logic exv, input logic [2:0] exr,
                                     input logic exl, input logic dmv, input logic [2:0] dmr,
                                     input logic wbv, input logic [2:0] wbr);
    return s == 3'd0 ? 2'b00 :
           exv && exr == s && !exl ? 2'b01 :
           dmv && dmr == s ? 2'b10 :
           wbv && wbr == s ? 2'b11 : 2'b00;
  endfunction

  assign unused = ^ins[10:0];

  always_comb begin
    op = ins[23:20];
    rd = ins[19:17];
    rs1 = ins[16:14];
    rs2 = ins[13:11];
    is_r = op != 4'd0 && !op[3];
    is_i = op[3:2] == 2'b10;
    is_ld = op == 4'hc;
    is_st = op == 4'hd;
    rd_a = ins_valid && (is_r || is_i || is_ld || is_st);
    rd_b = ins_valid && (is_r || is_st);
    wr = ins_valid && (is_r || is_i || is_ld) && rd != 3'd0;
    imm_sel = ins_valid && (is_i || is_ld || is_st);
    mux_sel_A = rd_a ? fwd(rs1, ex_v_q, ex_rd_q, ex_ld_q, dm_v_q, dm_rd_q, wb_v_q, wb_rd_q) : 2'b00;
    mux_sel_B = rd_b ? fwd(rs2, ex_v_q, ex_rd_q, ex_ld_q, dm_v_q, dm_rd_q, wb_v_q, wb_rd_q) : 2'b00;
    stall = ex_v_q && ex_ld_q && ex_rd_q != 3'd0 &&
            ((rd_a && rs1 == ex_rd_q) || (rd_b && rs2 == ex_rd_q));
    // interrupt and stall both inject a bubble; interrupt additionally kills DM
    bubble = interrupt || stall;
    ex_v_d = !bubble && wr;
    ex_rd_d = ex_v_d ? rd : 3'd0;
    ex_ld_d = ex_v_d && is_ld;
    dm_v_d = !interrupt && ex_v_q;
    dm_rd_d = ex_rd_q;
    wb_v_d = dm_v_q;
    wb_rd_d = dm_rd_q;
    wb_we = wb_v_q;
    wb_addr = wb_rd_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_v_q <= 1'b0;
      ex_ld_q <= 1'b0;
      ex_rd_q <= 3'd0;
      dm_v_q <= 1'b0;
      dm_rd_q <= 3'd0;
      wb_v_q <= 1'b0;
      wb_rd_q <= 3'd0;
    end else begin
      ex_v_q <= ex_v_d;
      ex_ld_q <= ex_ld_d;
      ex_rd_q <= ex_rd_d;
      dm_v_q <= dm_v_d;
      dm_rd_q <= dm_rd_d;
      wb_v_q <= wb_v_d;
      wb_rd_q <= wb_rd_d;
    end
  end
endmodule
